// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RISC-V M-extension unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU,
//   REM, REMU). Radix-2 shift-add multiply and restoring divide, one iteration
//   per clock, on operand magnitudes. The result sign is applied while the
//   last iteration is written back, so no extra cycle is spent on it.
//   Divide-by-zero and signed overflow are resolved at accept time and skip
//   the iteration phase.
//
// Parameters
//   n       operand/result width (even, >= 4)
//
// Ports
//   clock   in   system clock, rising edge
//   nReset  in   asynchronous active-low reset
//   Start   in   request, sampled only while idle
//   MDOp    in   funct3 opcode (000 MUL .. 111 REMU)
//   A, B    in   operands, captured on the accepting edge
//   Busy    out  operation in progress (CALC or DONE)
//   Done    out  one-cycle pulse, MDOut valid
//   MDOut   out  result, held until the next accepted Start
//
// Build option
//   MULDIV_FAST_MUL_EN : multiplies use a single-cycle combinational 2n-bit
//                        multiplier and finish one cycle after acceptance.
//                        Divides are unaffected.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         Start,
    input  logic [2:0]   MDOp,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [n-1:0] MDOut
);

    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [2:0]      op_reg, op_reg_n;
    logic            neg_reg, neg_reg_n;
    logic [n-1:0]    mc_reg, mc_reg_n;     // multiplicand or divisor magnitude
    logic [n-1:0]    hi_reg, hi_reg_n;     // product high half / partial remainder
    logic [n-1:0]    lo_reg, lo_reg_n;     // multiplier then product low / dividend then quotient
    logic [CW-1:0]   count, count_n;
    logic [n-1:0]    res_reg, res_reg_n;

    // ---------------- input decode (used only in IDLE) ----------------
    logic          in_is_div;
    logic          in_a_signed, in_b_signed;
    logic          in_a_neg, in_b_neg;
    logic [n-1:0]  in_a_mag, in_b_mag;
    logic          in_b_zero, in_ovf, in_special;
    logic [n-1:0]  special_res;
    logic          in_neg;
    logic          take_short;
    logic [n-1:0]  short_res;

    always_comb begin
        in_is_div   = MDOp[2];
        in_a_signed = 1'b0;
        in_b_signed = 1'b0;
        case (MDOp)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                in_a_signed = 1'b1;
                in_b_signed = 1'b1;
            end
            3'b010: in_a_signed = 1'b1;
            default: ;
        endcase
        in_a_neg  = in_a_signed & A[n-1];
        in_b_neg  = in_b_signed & B[n-1];
        in_a_mag  = in_a_neg ? ('0 - A) : A;
        in_b_mag  = in_b_neg ? ('0 - B) : B;
        in_b_zero = (B == '0);
        in_ovf    = in_is_div && !MDOp[0] && (A == {1'b1, {(n-1){1'b0}}}) && (B == '1);
        in_special = in_is_div && (in_b_zero || in_ovf);
        // MDOp[1] separates REM/REMU from DIV/DIVU
        if (in_b_zero)
            special_res = MDOp[1] ? A : '1;
        else
            special_res = MDOp[1] ? '0 : A;
        // Remainder follows the dividend's sign; everything else xors the signs
        in_neg = (in_is_div && MDOp[1]) ? in_a_neg : (in_a_neg ^ in_b_neg);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*n-1:0] fast_a, fast_b, fast_prod;
    always_comb begin
        // Sign/zero extension to 2n bits makes an unsigned 2n-bit multiply
        // produce the correct low 2n bits for every signedness combination.
        fast_a     = {{n{in_a_neg}} | {n{in_a_signed & A[n-1]}}, A};
        fast_b     = {{n{in_b_signed & B[n-1]}}, B};
        fast_prod  = fast_a * fast_b;
        take_short = in_special | ~in_is_div;
        if (in_is_div)
            short_res = special_res;
        else if (MDOp == 3'b000)
            short_res = fast_prod[n-1:0];
        else
            short_res = fast_prod[2*n-1:n];
    end
`else
    always_comb begin
        take_short = in_special;
        short_res  = special_res;
    end
`endif

    // ---------------- one iteration of the core ----------------
    logic [n:0]     mul_sum;
    logic [n-1:0]   mul_hi, mul_lo;
    logic [n:0]     div_shift, div_diff;
    logic           div_ok;
    logic [n-1:0]   div_hi, div_lo;
    logic [n-1:0]   step_hi, step_lo;
    logic [2*n-1:0] prod_raw, prod_fix;
    logic [n-1:0]   quot_fix, rem_fix;
    logic [n-1:0]   final_res;

    always_comb begin
        // shift-add: add multiplicand when multiplier LSB set, shift right
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mc_reg} : '0);
        mul_hi  = mul_sum[n:1];
        mul_lo  = {mul_sum[0], lo_reg[n-1:1]};

        // restoring: trial subtract from shifted remainder; a clear top bit
        // of the n+1 bit difference means no borrow
        div_shift = {hi_reg, lo_reg[n-1]};
        div_diff  = div_shift - {1'b0, mc_reg};
        div_ok    = ~div_diff[n];
        div_hi    = div_ok ? div_diff[n-1:0] : div_shift[n-1:0];
        div_lo    = {lo_reg[n-2:0], div_ok};

        step_hi = op_reg[2] ? div_hi : mul_hi;
        step_lo = op_reg[2] ? div_lo : mul_lo;

        prod_raw = {step_hi, step_lo};
        prod_fix = neg_reg ? ('0 - prod_raw) : prod_raw;
        quot_fix = neg_reg ? ('0 - step_lo) : step_lo;
        rem_fix  = neg_reg ? ('0 - step_hi) : step_hi;

        case (op_reg)
            3'b000:                 final_res = prod_fix[n-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*n-1:n];
            3'b100, 3'b101:         final_res = quot_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // ---------------- next-state / datapath control ----------------
    always_comb begin
        state_n   = state;
        op_reg_n  = op_reg;
        neg_reg_n = neg_reg;
        mc_reg_n  = mc_reg;
        hi_reg_n  = hi_reg;
        lo_reg_n  = lo_reg;
        count_n   = count;
        res_reg_n = res_reg;

        case (state)
            IDLE: begin
                if (Start) begin
                    op_reg_n  = MDOp;
                    neg_reg_n = in_neg;
                    count_n   = '0;
                    hi_reg_n  = '0;
                    if (in_is_div) begin
                        mc_reg_n = in_b_mag;
                        lo_reg_n = in_a_mag;
                    end else begin
                        mc_reg_n = in_a_mag;
                        lo_reg_n = in_b_mag;
                    end
                    if (take_short) begin
                        res_reg_n = short_res;
                        state_n   = DONE;
                    end else begin
                        state_n   = CALC;
                    end
                end
            end
            CALC: begin
                hi_reg_n = step_hi;
                lo_reg_n = step_lo;
                count_n  = count + CW'(1);
                if (count == CW'(n - 1)) begin
                    res_reg_n = final_res;
                    state_n   = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            op_reg  <= '0;
            neg_reg <= 1'b0;
            mc_reg  <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            count   <= '0;
            res_reg <= '0;
        end else begin
            state   <= state_n;
            op_reg  <= op_reg_n;
            neg_reg <= neg_reg_n;
            mc_reg  <= mc_reg_n;
            hi_reg  <= hi_reg_n;
            lo_reg  <= lo_reg_n;
            count   <= count_n;
            res_reg <= res_reg_n;
        end
    end

    assign Busy  = (state != IDLE);
    assign Done  = (state == DONE);
    assign MDOut = res_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit (n = 32). Each record gives
//   opcode, operands, expected result and the cycle in which Done must rise
//   (cycle 0 = the cycle whose closing edge accepts Start). Hand-written
//   sequences cover Start held high and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int N = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic          clock;
    logic          nReset;
    logic          Start;
    logic [2:0]    MDOp;
    logic [N-1:0]  A, B;
    logic          Busy, Done;
    logic [N-1:0]  MDOut;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.n(N)) dut (
        .clock  (clock),
        .nReset (nReset),
        .Start  (Start),
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .MDOut  (MDOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // Drive one request, follow it to Done, check result, latency, Busy
    // throughout, and the return to idle one cycle later.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int  cyc;
        bit  seen;
        bit  busy_ok;
        @(negedge clock);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge clock); #1;
        Start = 1'b0;
        // operands must have been captured already
        A = $urandom; B = $urandom; MDOp = 3'($urandom);
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && cyc <= 100) begin
            if (!Busy) busy_ok = 1'b0;
            if (Done) seen = 1'b1;
            else begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        check({name, "_result"}, MDOut, exp);
        check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        @(posedge clock); #1;
        check({name, "_idle_after"}, {30'd0, Busy, Done}, 32'd0);
        check({name, "_hold"}, MDOut, exp);
    endtask

    initial begin
        int cyc;
        bit seen;
        int done_pulses;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
        vecs[1]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};
        vecs[2]  = '{3'b011, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[5]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, MUL_LAT};
        vecs[6]  = '{3'b000, 32'd0,          32'd5,        32'h00000000, MUL_LAT};
        vecs[7]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, DIV_LAT};
        vecs[8]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, DIV_LAT};
        vecs[9]  = '{3'b101, 32'd100,        32'd7,        32'd14,       DIV_LAT};
        vecs[10] = '{3'b111, 32'd100,        32'd7,        32'd2,        DIV_LAT};
        vecs[11] = '{3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
        vecs[12] = '{3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        DIV_LAT};
        vecs[13] = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{3'b110, 32'd5,          32'd0,        32'd5,        1};
        vecs[15] = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
        vecs[16] = '{3'b111, 32'd5,          32'd0,        32'd5,        1};
        vecs[17] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[18] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[19] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'd0,        DIV_LAT};

        // reset state
        nReset = 1'b0; Start = 1'b0; MDOp = '0; A = '0; B = '0;
        #12;
        check("reset_busy_done", {30'd0, Busy, Done}, 32'd0);
        check("reset_mdout", MDOut, 32'd0);
        @(negedge clock);
        nReset = 1'b1;

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Start held high with operands changing every cycle: only the
        // cycle-0 request may be taken.
        @(negedge clock);
        Start = 1'b1; MDOp = 3'b000; A = 32'd7; B = 32'hFFFFFFFD;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            @(posedge clock); #1;
            cyc++;
            A = $urandom; B = $urandom; MDOp = 3'($urandom);
            if (Done) begin
                seen = 1'b1;
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        check("held_start_latency", 32'(cyc), 32'(MUL_LAT));
        check("held_start_result", MDOut, 32'hFFFFFFEB);
        repeat (3) @(posedge clock);
        #1;
        check("held_start_idle_hold", {Busy, Done, MDOut[29:0]}, {2'b00, 30'h3FFFFFEB});

        // Reset pulsed at cycle 10 of a long divide.
        @(negedge clock);
        Start = 1'b1; MDOp = 3'b101; A = 32'd100; B = 32'd7;
        @(posedge clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge clock);
        #3;
        nReset = 1'b0;
        #1;
        check("midop_reset_busy_done", {30'd0, Busy, Done}, 32'd0);
        check("midop_reset_mdout", MDOut, 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        done_pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (Done || Busy) done_pulses++;
        end
        check("midop_reset_no_done", 32'(done_pulses), 32'd0);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
